data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Data-memory slave that serves the RISC-V core's load/store port (rd, wr, 9-bit byte address, 32-bit data). It adds a configurable access latency, byte, half and word sizing with sign/zero extension, and a busy stall back to the core. It sits between the core's MEM stage and a 512-byte word-organised RAM held inside the block, replacing the zero-latency behavioural memory.

Parameters:
ADDR_W, 9, byte-address width
DATA_W, 32, data width
DEPTH_WORDS, 128, RAM depth in 32-bit words (2^ADDR_W / 4)
WAIT_CYCLES, 2, wait states inserted before the access completes (0 allowed)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rd  in  1  load request from core, held until done
wr  in  1  store request from core, held until done
funct3  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000 sb, 001 sh, 010 sw
addr  in  ADDR_W  byte address
wr_data  in  DATA_W  store data, right-aligned
rd_data  out  DATA_W  load result, extended, valid while done=1
busy  out  1  combinational stall to core
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset (reset=0, async): state=IDLE, rd_data=0, done=0, err=0, wait counter=0. RAM contents are not cleared and are undefined until written.
- FSM states: IDLE, WAIT, RESP.
- IDLE, no request (rd=wr=0): stay in IDLE. busy=0.
- IDLE, request (rd^wr or rd&wr): capture op, addr, funct3 and wr_data into registers. busy=1 in the capture cycle.
  - Error case: go to RESP without touching RAM. The request is an error if any of these hold: rd&wr both set; funct3 illegal for the op (load: 011/110/111; store: anything but 000/001/010); misaligned (half with addr[0]=1, word with addr[1:0]!=0).
  - WAIT_CYCLES=0 and legal: perform the access on this edge and go to RESP.
  - Otherwise: counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT: busy=1. Decrement the counter each cycle. When the counter is 0, perform the access on that edge and go to RESP.
- RESP: done=1 and busy=0, so the core advances at the end of this cycle. err=1 only for an error case. Next state is IDLE unconditionally. Any rd/wr seen in the following IDLE cycle is a new request.
- Latency: a request first seen in IDLE at cycle T gets done at cycle T+WAIT_CYCLES+1.
- Store access: word index = addr[ADDR_W-1:2]. Byte lane = addr[1:0]; half lane = addr[1]. Only the addressed lanes are written; other bytes are unchanged. rd_data holds its previous value.
- Load access:
  - Byte or half selected by lane.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw is the full word.
  - rd_data is registered at the access edge and holds until the next load completes.
- Error responses: rd_data=0. No RAM write.
- Request inputs are sampled only in IDLE; changes during WAIT/RESP are ignored.
- Reset mid-operation: returns to IDLE immediately and the pending access is dropped. A store is committed only if its access edge preceded reset assertion.

Test Plan:
- Reset held, then released with rd=wr=0 -> rd_data=0, done=0, err=0, busy=0 for 5 cycles.
- WAIT_CYCLES=2: sw addr=0x010, data=0xDEADBEEF, then lw addr=0x010 -> each gets done 3 cycles after request; busy high 3 cycles (capture plus 2 WAIT); rd_data=0xDEADBEEF.
- Sub-word access:
  - Setup: word at 0x020 = 0x000080F0. sb addr=0x022 data=0x7F -> word=0x007F80F0.
  - lb 0x020 -> 0xFFFFFFF0; lbu 0x020 -> 0x000000F0.
  - lh 0x020 -> 0xFFFF80F0; lhu 0x020 -> 0x000080F0.
- Misaligned and illegal:
  - lw addr=0x013 -> done and err pulse; rd_data=0.
  - sh addr=0x011 -> err; a following lw 0x010 shows the word unchanged.
  - rd&wr together -> err, no write.
- Back-to-back: a new lw presented in the cycle after done is accepted; WAIT_CYCLES=0 gives done on every second cycle.
- Reset during WAIT of sw 0x030=0x12345678 (word previously 0x0) -> FSM returns to IDLE; subsequent lw 0x030 returns 0x00000000.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory slave for the core's load/store port: 512-byte word RAM with
// configurable wait states, byte/half/word sizing, sign/zero extension and error pulses.
module data_mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t              state_q;
  logic                op_rd_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                done_q;
  logic                err_q;
  logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];

  logic                req;
  logic                req_err;
  logic                in_idle;
  logic                acc_rd;
  logic [2:0]          acc_f3;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wd;
  logic                acc_fire;
  logic                mem_we;
  logic [DATA_W-1:0]   word;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;
  logic [DATA_W-1:0]   load_val;
  logic [3:0]          be;
  logic [DATA_W-1:0]   wd_rep;

  assign req = rd | wr;

  always_comb begin
    req_err = 1'b0;
    if (rd && wr) begin
      req_err = 1'b1;
    end else if (rd) begin
      req_err = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else begin
      req_err = !(funct3 inside {3'b000, 3'b001, 3'b010});
    end
    if ((funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00))
      req_err = 1'b1;
  end

  // With zero wait states the access happens on the capture edge, so the
  // datapath looks at the live inputs in IDLE and at the captured copy otherwise.
  assign in_idle  = (state_q == S_IDLE);
  assign acc_rd   = in_idle ? rd      : op_rd_q;
  assign acc_f3   = in_idle ? funct3  : f3_q;
  assign acc_addr = in_idle ? addr    : addr_q;
  assign acc_wd   = in_idle ? wr_data : wdata_q;
  assign acc_fire = reset && (in_idle ? (NO_WAIT && req && !req_err)
                                      : (state_q == S_WAIT && cnt_q == '0));
  assign mem_we   = acc_fire && !acc_rd;

  assign word   = mem_q[acc_addr[ADDR_W-1:2]];
  assign byte_v = word[{acc_addr[1:0], 3'b000} +: 8];
  assign half_v = acc_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_val = word;
    case (acc_f3)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b100:  load_val = {24'd0, byte_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = word;
    endcase
  end

  always_comb begin
    be     = 4'b1111;
    wd_rep = acc_wd;
    case (acc_f3[1:0])
      2'b00: begin
        be     = 4'b0001 << acc_addr[1:0];
        wd_rep = {4{acc_wd[7:0]}};
      end
      2'b01: begin
        be     = acc_addr[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{acc_wd[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wd_rep = acc_wd;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[acc_addr[ADDR_W-1:2]][8*b +: 8] <= wd_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_rd_q   <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (req) begin
            op_rd_q <= rd;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wr_data;
            if (req_err) begin
              state_q   <= S_RESP;
              done_q    <= 1'b1;
              err_q     <= 1'b1;
              rd_data_q <= '0;
            end else if (NO_WAIT) begin
              state_q <= S_RESP;
              done_q  <= 1'b1;
              if (rd) rd_data_q <= load_val;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_RESP;
            done_q  <= 1'b1;
            if (op_rd_q) rd_data_q <= load_val;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (in_idle && req) || (state_q == S_WAIT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-array reference model plus expected-response
// queues checked on every done pulse; a second instance covers zero wait states.
module tb_data_mem_responder;

  localparam int WAITS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [2:0]  funct3;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic [1:0]  dbg_state;

  logic        rd0, wr0;
  logic [2:0]  funct3_0;
  logic [8:0]  addr0;
  logic [31:0] wr_data0;
  logic [31:0] rd_data0;
  logic        busy0, done0, err0;
  logic [1:0]  dbg_state0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_err_q[$];
  int          exp_cyc_q[$];

  logic [7:0]  mm [512];
  logic [31:0] last_rd;

  data_mem_responder #(.WAIT_CYCLES(WAITS)) u_dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .funct3(funct3), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .rd(rd0), .wr(wr0), .funct3(funct3_0), .addr(addr0),
    .wr_data(wr_data0), .rd_data(rd_data0), .busy(busy0), .done(done0), .err(err0),
    .dbg_state(dbg_state0)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model
  function automatic logic m_err(input logic r, input logic w, input logic [2:0] f3,
                                 input logic [8:0] a);
    if (r && w) return 1'b1;
    if (r) begin
      case (f3)
        3'b000, 3'b100: return 1'b0;
        3'b001, 3'b101: return a[0];
        3'b010:         return a[1:0] != 2'b00;
        default:        return 1'b1;
      endcase
    end
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [8:0] a);
    int i;
    i = int'(a);
    case (f3)
      3'b000:  return {{24{mm[i][7]}}, mm[i]};
      3'b100:  return {24'h0, mm[i]};
      3'b001:  return {{16{mm[i+1][7]}}, mm[i+1], mm[i]};
      3'b101:  return {16'h0, mm[i+1], mm[i]};
      default: return {mm[i+3], mm[i+2], mm[i+1], mm[i]};
    endcase
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd);
    int i;
    i = int'(a);
    mm[i] = wd[7:0];
    if (f3 != 3'b000) mm[i+1] = wd[15:8];
    if (f3 == 3'b010) begin
      mm[i+2] = wd[23:16];
      mm[i+3] = wd[31:24];
    end
  endtask

  // driver: request held until done, dropped or replaced right after the RESP edge
  task automatic do_req(input logic r, input logic w, input logic [2:0] f3,
                        input logic [8:0] a, input logic [31:0] wd);
    logic e;
    int   nb;
    logic got;
    @(posedge clk); #1;
    rd = r; wr = w; funct3 = f3; addr = a; wr_data = wd;
    e = m_err(r, w, f3, a);
    if (e)      last_rd = 32'h0;
    else if (r) last_rd = m_load(f3, a);
    else        m_store(f3, a, wd);
    exp_q.push_back(last_rd);
    exp_err_q.push_back({31'd0, e});
    exp_cyc_q.push_back(cyc + (e ? 1 : WAITS + 1));
    nb  = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
    check("busy_cycles", nb, e ? 32'd1 : WAITS + 1);
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (reset && err && !done) check("err_without_done", {31'd0, err}, 32'd0);
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd0, 32'd1);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
        check("err", {31'd0, err}, exp_err_q.pop_front());
        check("latency", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0;
    rd = 1'b0; wr = 1'b0; funct3 = 3'b0; addr = '0; wr_data = '0;
    rd0 = 1'b0; wr0 = 1'b0; funct3_0 = 3'b0; addr0 = '0; wr_data0 = '0;
    last_rd = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_rd_data", rd_data, 32'h0);
      check("post_reset_flags", {29'd0, done, err, busy}, 32'd0);
    end

    // word store/load with latency
    do_req(1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    go_idle(1);

    // sub-word access
    do_req(1'b0, 1'b1, 3'b010, 9'h020, 32'h000080F0);
    do_req(1'b0, 1'b1, 3'b000, 9'h022, 32'h0000007F);
    do_req(1'b1, 1'b0, 3'b010, 9'h020, 32'h0);
    check("sb_merge_word", rd_data, 32'h007F80F0);
    do_req(1'b1, 1'b0, 3'b000, 9'h020, 32'h0);
    check("lb_const", rd_data, 32'hFFFFFFF0);
    do_req(1'b1, 1'b0, 3'b100, 9'h020, 32'h0);
    do_req(1'b1, 1'b0, 3'b001, 9'h020, 32'h0);
    check("lh_const", rd_data, 32'hFFFF80F0);
    do_req(1'b1, 1'b0, 3'b101, 9'h020, 32'h0);
    do_req(1'b1, 1'b0, 3'b001, 9'h022, 32'h0);
    do_req(1'b1, 1'b0, 3'b000, 9'h023, 32'h0);
    go_idle(2);

    // misaligned / illegal
    do_req(1'b1, 1'b0, 3'b010, 9'h013, 32'h0);
    do_req(1'b0, 1'b1, 3'b001, 9'h011, 32'h0000AAAA);
    do_req(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    do_req(1'b1, 1'b1, 3'b010, 9'h010, 32'h11111111);
    do_req(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    check("word_unchanged", rd_data, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 3'b011, 9'h010, 32'h0);
    do_req(1'b0, 1'b1, 3'b100, 9'h010, 32'h22222222);
    do_req(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    go_idle(1);

    // random traffic over an initialised window
    for (int i = 0; i < 8; i++) do_req(1'b0, 1'b1, 3'b010, 9'h100 + 9'(4*i), $urandom);
    for (int i = 0; i < 30; i++) begin
      logic [2:0] f3;
      logic       r;
      r  = 1'($urandom_range(0, 1));
      f3 = r ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2));
      do_req(r, ~r, f3, 9'h100 + 9'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 3) == 0) go_idle($urandom_range(0, 2));
    end
    go_idle(1);

    // reset in the middle of a store's wait states
    do_req(1'b0, 1'b1, 3'b010, 9'h030, 32'h0);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b1; funct3 = 3'b010; addr = 9'h030; wr_data = 32'h12345678;
    @(posedge clk); #1;
    check("in_wait_state", {30'd0, dbg_state}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset_idle", {30'd0, dbg_state}, 32'd0);
    check("async_reset_done", {31'd0, done}, 32'd0);
    rd = 1'b0; wr = 1'b0;
    last_rd = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    do_req(1'b1, 1'b0, 3'b010, 9'h030, 32'h0);
    check("dropped_store", rd_data, 32'h00000000);
    go_idle(1);

    // zero wait states: back-to-back completion every second cycle
    @(posedge clk); #1;
    wr0 = 1'b1; funct3_0 = 3'b010; addr0 = 9'h040; wr_data0 = 32'hCAFEF00D;
    @(negedge clk);
    check("w0_capture_flags", {30'd0, busy0, done0}, 32'b10);
    @(negedge clk);
    check("w0_resp_flags", {30'd0, busy0, done0}, 32'b01);
    @(posedge clk); #1;
    wr0 = 1'b0; rd0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("w0_done_pattern", {31'd0, done0}, 32'(k % 2));
      if (done0) check("w0_rd_data", rd_data0, 32'hCAFEF00D);
      check("w0_err", {31'd0, err0}, 32'd0);
    end
    @(posedge clk); #1;
    rd0 = 1'b0;

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
